// File: rtl/out_port_arb.sv
// ---------------------------------------------------------------------------
// out_port_arb
// Round-robin arbiter guarding one output port of the multi-port cache switch.
// Collects the request bit for this port from every input port, issues a
// one-cycle one-hot grant on o_resp and then holds the port for the winner
// until i_finish releases it. The round-robin pointer advances past the
// registered winner, so a continuously requesting port waits at most
// NUM_PORT-1 grants.
//
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog. It releases a
// transfer that has not finished after TIMEOUT_CYC cycles in XFER and pulses
// o_timeout. In the default build o_timeout is tied low and XFER waits on
// i_finish indefinitely.
// ---------------------------------------------------------------------------
module out_port_arb #(
    parameter int NUM_PORT    = 16,
    parameter int PORT_W      = $clog2(NUM_PORT),
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_PORT-1:0] i_req,
    input  logic                i_port_ready,
    input  logic                i_finish,
    output logic [NUM_PORT-1:0] o_resp,
    output logic [PORT_W-1:0]   o_grant_id,
    output logic                o_grant_vld,
    output logic                o_busy,
    output logic                o_timeout
);

    // Reject configurations the natural pointer wrap cannot support.
    if ((NUM_PORT < 2) || ((NUM_PORT & (NUM_PORT - 1)) != 0) || (TIMEOUT_CYC < 2)) begin : g_cfg_err
        $error("out_port_arb: NUM_PORT must be a power of 2 >= 2 and TIMEOUT_CYC >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t                state_r,     state_s;
    logic [PORT_W-1:0]     rr_ptr_r,    rr_ptr_s;
    logic [NUM_PORT-1:0]   resp_r,      resp_s;
    logic [PORT_W-1:0]     grant_id_r,  grant_id_s;
    logic                  grant_vld_r, grant_vld_s;
    logic                  busy_r,      busy_s;
    logic                  timeout_r,   timeout_s;
    logic [PORT_W-1:0]     win_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0]      cnt_r, cnt_s;
`endif

    // First set request bit at or above ptr, wrapping through NUM_PORT-1 -> 0.
    function automatic logic [PORT_W-1:0] rr_pick(
        input logic [NUM_PORT-1:0] req,
        input logic [PORT_W-1:0]   ptr
    );
        logic [PORT_W-1:0] idx;
        logic [PORT_W-1:0] sel;
        logic              found;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_PORT; i++) begin
            idx = ptr + PORT_W'(i);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end else begin
                sel   = sel;
                found = found;
            end
        end
        return sel;
    endfunction

    // Round-robin winner for the current request vector.
    always_comb begin
        win_s = rr_pick(i_req, rr_ptr_r);
    end

    // Next-state and next-output computation for the ownership FSM.
    always_comb begin
        state_s     = state_r;
        rr_ptr_s    = rr_ptr_r;
        resp_s      = {NUM_PORT{1'b0}};
        grant_id_s  = grant_id_r;
        grant_vld_s = grant_vld_r;
        busy_s      = busy_r;
        timeout_s   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_s       = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (i_port_ready && (|i_req)) begin
                    state_s     = ST_GRANT;
                    grant_id_s  = win_s;
                    resp_s      = {{(NUM_PORT-1){1'b0}}, 1'b1} << win_s;
                    grant_vld_s = 1'b1;
                    busy_s      = 1'b1;
                end else begin
                    grant_vld_s = 1'b0;
                    busy_s      = 1'b0;
                end
            end
            ST_GRANT: begin
                // Grant pulse lasts one cycle; i_finish is not looked at here.
                state_s = ST_XFER;
`ifdef ARB_TIMEOUT_EN
                cnt_s   = {CNT_W{1'b0}};
`endif
            end
            ST_XFER: begin
                if (i_finish) begin
                    state_s     = ST_IDLE;
                    rr_ptr_s    = grant_id_r + PORT_W'(1);
                    grant_vld_s = 1'b0;
                    busy_s      = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_r == CNT_LAST) begin
                    state_s     = ST_IDLE;
                    rr_ptr_s    = grant_id_r + PORT_W'(1);
                    grant_vld_s = 1'b0;
                    busy_s      = 1'b0;
                    timeout_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
`else
                else begin
                    state_s = ST_XFER;
                end
`endif
            end
            default: begin
                state_s     = ST_IDLE;
                grant_vld_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // State, pointer and registered outputs; reset aborts any ownership.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {PORT_W{1'b0}};
            resp_r      <= {NUM_PORT{1'b0}};
            grant_id_r  <= {PORT_W{1'b0}};
            grant_vld_r <= 1'b0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            rr_ptr_r    <= rr_ptr_s;
            resp_r      <= resp_s;
            grant_id_r  <= grant_id_s;
            grant_vld_r <= grant_vld_s;
            busy_r      <= busy_s;
            timeout_r   <= timeout_s;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter measuring time spent in XFER.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end
`endif

    assign o_resp      = resp_r;
    assign o_grant_id  = grant_id_r;
    assign o_grant_vld = grant_vld_r;
    assign o_busy      = busy_r;
    assign o_timeout   = timeout_r;

endmodule

// File: tb/tb_out_port_arb.sv
// ---------------------------------------------------------------------------
// tb_out_port_arb
// Scoreboard bench for out_port_arb. The driver changes inputs on the falling
// edge and advances a behavioural ownership model; predicted grants are queued
// and a separate monitor compares DUT outputs just after each rising edge.
// ---------------------------------------------------------------------------
module tb_out_port_arb;

    localparam int N  = 16;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          ready;
    logic          finish;
    logic [N-1:0]  resp;
    logic [3:0]    gid;
    logic          gvld;
    logic          busy;
    logic          tmo;

    always #5 clk = ~clk;

    out_port_arb dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_port_ready (ready),
        .i_finish     (finish),
        .o_resp       (resp),
        .o_grant_id   (gid),
        .o_grant_vld  (gvld),
        .o_busy       (busy),
        .o_timeout    (tmo)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: who owns the port, whether the grant was just issued,
    // where the next search starts and how long the transfer has run.
    bit m_owned = 1'b0;
    bit m_fresh = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    // Expected post-edge output levels.
    bit e_vld = 1'b0;
    bit e_busy = 1'b0;
    bit e_to = 1'b0;
    int e_id = 0;

    int  exp_q[$];
    int  seen_q[$];
    bit  mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (r[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic void release_port();
        m_owned = 1'b0;
        m_ptr   = (m_owner + 1) % N;
    endfunction

    // Advance the model by one rising edge using the inputs just driven.
    function automatic void step();
        int w;
        e_to = 1'b0;
        if (!m_owned) begin
            if (ready && (req != '0)) begin
                w       = pick(req, m_ptr);
                m_owned = 1'b1;
                m_fresh = 1'b1;
                m_owner = w;
                exp_q.push_back(w);
            end
        end else if (m_fresh) begin
            m_fresh = 1'b0;
            m_cnt   = 0;
        end else if (finish) begin
            release_port();
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_cnt == TO - 1) begin
            release_port();
            e_to = 1'b1;
        end
`endif
        else begin
            m_cnt++;
        end
        e_vld  = m_owned;
        e_busy = m_owned;
        e_id   = m_owner;
    endfunction

    task automatic cycle(input logic [N-1:0] r, input bit rdy, input bit fin);
        @(negedge clk);
        req    = r;
        ready  = rdy;
        finish = fin;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp"},  int'(resp), 0);
        check({tag, "_id"},    int'(gid),  0);
        check({tag, "_vld"},   int'(gvld), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_tmo"},   int'(tmo),  0);
    endtask

    // Assert reset mid-cycle, verify outputs clear at once, then release.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst    = 1'b1;
        req    = '0;
        ready  = 1'b0;
        finish = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        m_owned = 1'b0;
        m_fresh = 1'b0;
        m_ptr   = 0;
        m_owner = 0;
        e_vld   = 1'b0;
        e_busy  = 1'b0;
        e_to    = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Hold r with ready high; pulse finish d cycles after each grant until
    // ngr transfers have been released.
    task automatic serve(input logic [N-1:0] r, input int d, input int ngr);
        int got    = 0;
        int since  = 0;
        int budget = 0;
        bit fin;
        while (got < ngr && budget < 2000) begin
            fin = m_owned && !m_fresh && (since >= d);
            cycle(r, 1'b1, fin);
            if (fin) got++;
            if (m_fresh) since = 1;
            else if (m_owned) since++;
            else since = 0;
            budget++;
        end
        if (got < ngr) check("serve_budget", got, ngr);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle('0, 1'b1, 1'b0);
    endtask

    // Monitor: compare registered outputs against the model after each edge.
    always @(posedge clk) begin
        int w;
        #1;
        if (mon_en && !rst) begin
            check("grant_vld", int'(gvld), int'(e_vld));
            check("busy",      int'(busy), int'(e_busy));
            check("timeout",   int'(tmo),  int'(e_to));
            if (e_vld) check("grant_id", int'(gid), e_id);
            check("resp_present", int'(resp != '0), int'(exp_q.size() != 0));
            if (resp != '0 && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("resp_onehot", int'(resp), 1 << w);
                seen_q.push_back(int'(gid));
            end
        end
    end

    // Global watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst    = 1'b1;
        req    = '0;
        ready  = 1'b0;
        finish = 1'b0;
        #1;
        check_reset_outputs("rst_init");
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single requester, basic grant/finish timing.
        idle(2);
        cycle(16'h0001, 1'b1, 1'b0);
        repeat (4) cycle(16'h0001, 1'b1, 1'b0);
        cycle(16'h0000, 1'b1, 1'b1);
        idle(3);

        // All ports requesting: grants must rotate 0..15 then 0.
        do_reset();
        seen_q.delete();
        serve(16'hFFFF, 3, 17);
        idle(2);
        check("rr_count", seen_q.size(), 17);
        for (int i = 0; i < 17 && i < seen_q.size(); i++)
            check($sformatf("rr_seq_%0d", i), seen_q[i], i % 16);

        // Wrap-around from ptr 1 with ports 0 and 15 requesting.
        do_reset();
        seen_q.delete();
        serve(16'h0001, 3, 1);
        serve(16'h8001, 2, 2);
        idle(2);
        check("wrap_count", seen_q.size(), 3);
        if (seen_q.size() == 3) begin
            check("wrap_first",  seen_q[1], 15);
            check("wrap_second", seen_q[2], 0);
        end

        // Port not ready: request must wait, then win once ready rises.
        seen_q.delete();
        repeat (20) cycle(16'h0010, 1'b0, 1'b0);
        cycle(16'h0010, 1'b1, 1'b0);
        repeat (3) cycle(16'h0010, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b1);
        idle(2);
        check("ready_grant_count", seen_q.size(), 1);
        if (seen_q.size() == 1) check("ready_grant_id", seen_q[0], 4);

        // Reset during a transfer owned by port 5, then restart from ptr 0.
        do_reset();
        cycle(16'h0020, 1'b1, 1'b0);
        repeat (3) cycle(16'h0000, 1'b1, 1'b0);
        check("pre_rst_owner", int'(gid), 5);
        do_reset();
        seen_q.delete();
        serve(16'h0021, 2, 1);
        idle(2);
        if (seen_q.size() >= 1) check("post_rst_grant", seen_q[0], 0);
        else check("post_rst_grant_count", seen_q.size(), 1);

        // No finish for 50 cycles: ownership persists (no watchdog here).
        cycle(16'h0004, 1'b1, 1'b0);
        repeat (50) cycle(16'h0004, 1'b1, 1'b0);
        cycle(16'h0000, 1'b1, 1'b1);
        idle(2);

        // Randomised traffic, including stray finish pulses.
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] r;
            r = N'($urandom) & N'($urandom) & N'($urandom);
            cycle(r, ($urandom % 4) != 0, ($urandom % 4) == 0);
        end
        cycle('0, 1'b1, 1'b1);
        idle(3);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/out_port_arb.md
Name: out_port_arb

Overview:
- Per-output-port arbiter for the multi-port cache switch; one instance per output port (16 total).
- Collects the request bit for this output port from every input-port `port_req` (`o_req[k]` of each).
- Grants one requester at a time, round-robin, and returns a one-hot grant on `o_resp`. That bit fans back to the winning `port_req` as its `i_resp` bit.
- Holds the output port exclusively until the transfer signals finish, then re-arbitrates.

Parameters:
- NUM_PORT, 16, number of input-port requesters; must be a power of 2, ≥2.
- PORT_W, $clog2(NUM_PORT), width of port index.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req  in  NUM_PORT  request vector; bit k = input port k wants this output port; level, held until granted.
- i_port_ready  in  1  output port can accept a new packet (downstream buffer not full).
- i_finish  in  1  one-cycle pulse: granted packet fully read/transferred.
- o_resp  out  NUM_PORT  one-hot grant pulse, one cycle wide.
- o_grant_id  out  PORT_W  index of current owner; valid while o_grant_vld=1.
- o_grant_vld  out  1  port owned (GRANT or XFER state).
- o_busy  out  1  high whenever state ≠ IDLE.
- o_timeout  out  1  one-cycle pulse on watchdog release; constant 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, rr_ptr=0.
  - o_resp=0, o_grant_id=0, o_grant_vld=0, o_busy=0, o_timeout=0.
  - Takes effect immediately and aborts any grant mid-transfer. After release, first arbitration is from ptr 0.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE: on a clock edge with i_port_ready=1 and |i_req=1:
    - select winner w = first set bit of i_req searching upward from rr_ptr, wrapping NUM_PORT-1→0;
    - register o_grant_id=w, o_resp=(1<<w), o_grant_vld=1, o_busy=1;
    - go to GRANT.
    - If i_port_ready=0 or i_req=0, stay in IDLE; outputs stay low.
  - GRANT (exactly 1 cycle): o_resp is high this cycle only. Next edge: o_resp=0, go to XFER. i_finish is ignored in GRANT.
  - XFER: hold o_grant_id, o_grant_vld=1. On i_finish=1:
    - rr_ptr = w+1 (mod NUM_PORT, natural PORT_W-bit wrap);
    - o_grant_vld=0, o_busy=0;
    - go to IDLE.
- Latency:
  - Request sampled at edge N → o_resp visible in cycle N+1.
  - i_finish at edge M → earliest next o_resp in cycle M+2 (one IDLE cycle minimum between grants).
- i_req changes during GRANT/XFER are ignored. A requester that drops its request is not cleared from ownership; only i_finish (or timeout) releases.
- i_port_ready is sampled only in IDLE. A drop during XFER does not revoke the grant.
- Fairness: a continuously requesting port waits at most NUM_PORT-1 grants.
- i_finish arriving in IDLE is ignored (no state change, no error).
- The rr_ptr update uses the registered grant id, never the live i_req.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC)+1 clears on entry to XFER and increments each XFER cycle.
  - When it reaches TIMEOUT_CYC-1 without i_finish, the arbiter releases exactly as for i_finish (rr_ptr=w+1, IDLE) and pulses o_timeout for one cycle.
  - i_finish on the same edge takes precedence: no o_timeout pulse.
- Undefined: no counter logic; o_timeout tied to 0; XFER waits on i_finish forever.

Test Plan:
- Reset then i_req=16'h0001, i_port_ready=1 → o_resp=16'h0001 for exactly one cycle, o_grant_id=0, o_grant_vld=1 until i_finish pulse; then o_busy=0 one cycle later.
- i_req=16'hFFFF held, i_finish pulsed 3 cycles after each grant → grant ids sequence 0,1,2,…,15,0 with no repeats inside a 16-grant window.
- i_req=16'h8001 with rr_ptr=1 (after granting port 0) → next grant is port 15, then port 0 (wrap-around).
- i_port_ready=0 with i_req=16'h0010 → no o_resp for 20 cycles; raise i_port_ready → o_resp=16'h0010 on the following cycle.
- Assert i_rst mid-XFER (owner 5) → all outputs 0 immediately; after release with i_req=16'h0021, grant goes to port 0.
- With ARB_TIMEOUT_EN, TIMEOUT_CYC=8, no i_finish → o_timeout pulses once, 8 cycles after entering XFER, and rr_ptr advances. Without the macro, o_grant_vld stays 1 for the same 50 cycles and o_timeout stays 0.
